// File: rtl/conv12_seq_ctrl_if.sv
// Engine/RAM-side signal bundle for the 12x12 convolution frame sequencer.
// master = sequencer, slave = conv engine plus image/output RAMs.
interface conv12_seq_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
);
  logic              img_rd_en;
  logic [7:0]        img_rd_addr;
  logic [DATA_W-1:0] img_rd_data;
  logic              conv_rst;
  logic [DATA_W-1:0] conv_data;
  logic              conv_valid;
  logic [ACC_W-1:0]  conv_bias;
  logic [ACC_W-1:0]  conv_out;
  logic              conv_invalid;
  logic              conv_finish;
  logic              out_wr_en;
  logic [7:0]        out_wr_addr;
  logic [ACC_W-1:0]  out_wr_data;

  modport master (
    output img_rd_en, img_rd_addr, conv_rst, conv_data, conv_valid, conv_bias,
           out_wr_en, out_wr_addr, out_wr_data,
    input  img_rd_data, conv_out, conv_invalid, conv_finish
  );

  modport slave (
    input  img_rd_en, img_rd_addr, conv_rst, conv_data, conv_valid, conv_bias,
           out_wr_en, out_wr_addr, out_wr_data,
    output img_rd_data, conv_out, conv_invalid, conv_finish
  );
endinterface

// File: rtl/conv12_seq_ctrl.sv
// Frame sequencer: resets the conv engine, streams one image from RAM into it,
// writes every engine result to the output RAM, and reports done or err.
module conv12_seq_ctrl #(
  parameter int unsigned IMG_W   = 12,
  parameter int unsigned IMG_H   = 12,
  parameter int unsigned K       = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ACC_W-1:0] bias_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  conv12_seq_ctrl_if.master bus
);
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned OUT_N = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT);
  localparam logic [7:0]    PIX_LAST = 8'(NPIX - 1);
  localparam logic [7:0]    OUT_MAX  = 8'(OUT_N);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, FIN} state_t;

  state_t        state;
  logic [7:0]    rd_cnt;
  logic [7:0]    out_cnt;
  logic [TW-1:0] drain_cnt;
  logic          in_frame;
  logic          capture;
  logic          overflow;
  logic [DATA_W-1:0] pix;

  // Image RAM has one cycle of read latency, so its data lines up with conv_valid.
  assign pix             = bus.img_rd_data;
  assign bus.conv_data   = pix;
  assign bus.img_rd_addr = rd_cnt;

  always_comb begin
    in_frame = (state == FEED) || (state == DRAIN) || (state == FIN);
    capture  = in_frame && !bus.conv_invalid && (out_cnt != OUT_MAX);
    overflow = in_frame && !bus.conv_invalid && (out_cnt == OUT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rd_cnt          <= '0;
      out_cnt         <= '0;
      drain_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      bus.img_rd_en   <= 1'b0;
      bus.conv_rst    <= 1'b0;
      bus.conv_valid  <= 1'b0;
      bus.conv_bias   <= '0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_addr <= '0;
      bus.out_wr_data <= '0;
    end else begin
      bus.conv_valid <= bus.img_rd_en;
      bus.out_wr_en  <= 1'b0;
      if (capture) begin
        bus.out_wr_en   <= 1'b1;
        bus.out_wr_addr <= out_cnt;
        bus.out_wr_data <= bus.conv_out;
        out_cnt         <= out_cnt + 8'd1;
      end
      if (overflow) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state         <= CLR;
            busy          <= 1'b1;
            bus.conv_rst  <= 1'b1;
            bus.conv_bias <= bias_in;
            err           <= 1'b0;
            rd_cnt        <= '0;
            out_cnt       <= '0;
          end
        end
        CLR: begin
          bus.conv_rst  <= 1'b0;
          bus.img_rd_en <= 1'b1;
          state         <= FEED;
        end
        FEED: begin
          if (rd_cnt == PIX_LAST) begin
            bus.img_rd_en <= 1'b0;
            drain_cnt     <= '0;
            state         <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt != T_LAST) drain_cnt <= drain_cnt + 1'b1;
          // Finish only once the final write strobe has retired.
          if (out_cnt == OUT_MAX && !bus.out_wr_en) begin
            done  <= !(err || overflow);
            state <= FIN;
          end else if ((bus.conv_finish && out_cnt != OUT_MAX) || drain_cnt == T_LAST) begin
            err   <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv12_seq_ctrl.sv
// Self-checking bench for conv12_seq_ctrl: RAM and engine models, frame-level
// reference of expected writes, pixels, done/err and busy length.
module tb_conv12_seq_ctrl;
  localparam int NPIX   = 144;
  localparam int OUT_N  = 100;
  localparam int E_START = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] bias_in;
  logic        busy, done, err;

  conv12_seq_ctrl_if #(.DATA_W(16), .ACC_W(32)) bus ();

  conv12_seq_ctrl #(.IMG_W(12), .IMG_H(12), .K(3), .DATA_W(16), .ACC_W(32), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
    .busy(busy), .done(done), .err(err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] img_mem [NPIX];
  int eng_n = 0, eng_gap = 1, eng_cyc = 0, emitted = 0;
  bit eng_fin = 1'b0;
  logic [31:0] exp_q [$];

  int cyc = 0, vfirst = 0, vlast = 0, last_wr = 0, done_cyc = 0;
  int done_cnt = 0, rst_cnt = 0, busy_len = 0;
  bit busy_at_done = 1'b0;
  logic [15:0] pix_q [$];
  logic [7:0]  rda_q [$];
  logic [7:0]  wra_q [$];
  logic [31:0] wrd_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Image RAM: one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (bus.img_rd_en === 1'b1) bus.img_rd_data <= img_mem[bus.img_rd_addr];
  end

  // Engine model: after conv_rst, emits eng_n results every eng_gap cycles from cycle E_START
  initial begin
    bus.conv_invalid = 1'b1;
    bus.conv_finish  = 1'b0;
    bus.conv_out     = '0;
    forever begin
      @(negedge clk);
      if (bus.conv_rst === 1'b1) begin
        eng_cyc = 0; emitted = 0; exp_q.delete();
      end else begin
        eng_cyc++;
      end
      bus.conv_invalid = 1'b1;
      bus.conv_finish  = eng_fin && (emitted >= eng_n);
      if (eng_cyc >= E_START && emitted < eng_n && ((eng_cyc - E_START) % eng_gap) == 0) begin
        bus.conv_out     = $urandom;
        bus.conv_invalid = 1'b0;
        exp_q.push_back(bus.conv_out);
        emitted++;
      end
    end
  end

  // Observation of DUT outputs
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.conv_valid === 1'b1) begin
      if (pix_q.size() == 0) vfirst = cyc;
      vlast = cyc;
      pix_q.push_back(bus.conv_data);
    end
    if (bus.img_rd_en === 1'b1) rda_q.push_back(bus.img_rd_addr);
    if (bus.out_wr_en === 1'b1) begin
      wra_q.push_back(bus.out_wr_addr);
      wrd_q.push_back(bus.out_wr_data);
      last_wr = cyc;
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (bus.conv_rst === 1'b1) rst_cnt++;
    if (busy === 1'b1) busy_len++;
  end

  task automatic clear_obs();
    pix_q.delete(); rda_q.delete(); wra_q.delete(); wrd_q.delete();
    done_cnt = 0; rst_cnt = 0; busy_len = 0; last_wr = 0; done_cyc = 0;
    vfirst = 0; vlast = 0; busy_at_done = 1'b0;
  endtask

  task automatic load_image(input bit ones);
    for (int i = 0; i < NPIX; i++) img_mem[i] = ones ? 16'h0001 : 16'($urandom);
  endtask

  // Must be called at a negedge; start is raised immediately.
  task automatic run_frame(input int n, input int gap, input bit fin_en, input bit ones,
                           input logic [31:0] bias, input bit poke_mid, input bit poke_fin,
                           input int exp_blen, input int exp_dgap);
    bit seen_busy = 1'b0;
    bit ended = 1'b0;
    bit exp_err;
    int exp_nwr;
    load_image(ones);
    eng_n = n; eng_gap = gap; eng_fin = fin_en;
    clear_obs();
    bias_in = bias;
    start = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = (poke_mid && c == 60) || (poke_fin && done === 1'b1);
      if (busy === 1'b1) seen_busy = 1'b1;
      else if (seen_busy) begin ended = 1'b1; break; end
    end
    start = 1'b0;
    exp_err = (n != OUT_N);
    exp_nwr = (n < OUT_N) ? n : OUT_N;
    chk("frame_end", ended, 1);
    chk("err", err, exp_err);
    chk("done_cnt", done_cnt, !exp_err);
    chk("wr_count", wra_q.size(), exp_nwr);
    for (int i = 0; i < wra_q.size() && i < exp_nwr && i < exp_q.size(); i++) begin
      chk("wr_addr", wra_q[i], i);
      chk("wr_data", wrd_q[i], exp_q[i]);
    end
    chk("pix_count", pix_q.size(), NPIX);
    chk("valid_span", vlast - vfirst + 1, NPIX);
    for (int i = 0; i < pix_q.size() && i < NPIX; i++) chk("pix_data", pix_q[i], img_mem[i]);
    for (int i = 0; i < rda_q.size(); i++) chk("rd_addr", rda_q[i], i);
    chk("conv_rst_count", rst_cnt, 1);
    chk("conv_bias", bus.conv_bias, bias);
    if (!exp_err) chk("busy_at_done", busy_at_done, 1);
    if (exp_dgap != 0) chk("done_after_wr", done_cyc - last_wr, exp_dgap);
    if (exp_blen != 0) chk("busy_len", busy_len, exp_blen);
    if (poke_fin) begin
      repeat (3) @(negedge clk);
      chk("fin_start_ignored", busy, 0);
    end
  endtask

  initial begin
    bit found;
    int g, last;
    reset = 1'b1; start = 1'b0; bias_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, err, bus.img_rd_en, bus.img_rd_addr, bus.conv_rst,
                     bus.conv_valid, bus.out_wr_en, bus.out_wr_addr}, 0);
    chk("rst_data", {bus.conv_bias, bus.out_wr_data}, 0);
    reset = 1'b0;
    @(negedge clk);

    // T1 nominal: ones image, zero bias, contiguous results all inside FEED
    run_frame(100, 1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1 + NPIX + 1 + 1, 0);
    // T2 gapped results, finishing in DRAIN
    run_frame(100, 3, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 0, 2);
    // T3 overflow
    run_frame(101, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1 + NPIX + 1 + 1, 0);
    // Early engine finish with too few results
    run_frame(50, 1, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1 + NPIX + 1 + 1, 0);
    // T4 timeout: 50 results, no finish
    run_frame(50, 1, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 1 + NPIX + 4096 + 1, 0);
    // T5: start mid-FEED ignored; next frame started in first IDLE cycle; start in FIN ignored
    run_frame(100, 1, 1'b0, 1'b0, 32'h0000_0042, 1'b1, 1'b0, 0, 0);
    run_frame(100, 2, 1'b0, 1'b0, 32'h0000_0043, 1'b0, 1'b1, 0, 2);

    // Randomized nominal frames
    for (int k = 0; k < 3; k++) begin
      g = $urandom_range(1, 4);
      last = E_START + (OUT_N - 1) * g;
      run_frame(100, g, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, 0, (last >= NPIX) ? 2 : 0);
    end

    // T6 async reset mid-FEED
    load_image(1'b0);
    eng_n = 100; eng_gap = 1; eng_fin = 1'b0;
    bias_in = 32'hA5A5_0001;
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.img_rd_en === 1'b1 && bus.img_rd_addr === 8'd70) begin found = 1'b1; break; end
    end
    chk("reached_addr70", found, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_ctrl", {busy, done, err, bus.img_rd_en, bus.img_rd_addr, bus.conv_rst,
                      bus.conv_valid, bus.out_wr_en, bus.out_wr_addr}, 0);
    chk("arst_data", {bus.conv_bias, bus.out_wr_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(100, 1, 1'b0, 1'b0, 32'h7777_1111, 1'b0, 1'b0, 1 + NPIX + 1 + 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
